// File: rtl/qq_cmd_driver.sv
// Command-side driver for the quick queue: one queue operation at a time, occupancy tracking,
// rejection of illegal commands. Optional macro QQ_DRV_ERR_CNT_EN adds a saturating err_cnt output.
module qq_cmd_driver #(
  parameter int W         = 32,
  parameter int D         = 4,
  parameter int OP_CYCLES = 4,
  parameter int RD_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [W-1:0]       cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               q_enq,
  output logic               q_deq,
  output logic [W-1:0]       q_data_lt,
  output logic [31:0]        q_array_size,
  input  logic [W-1:0]       q_data_lt_o,
  output logic [$clog2(D):0] count
`ifdef QQ_DRV_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt
`endif
);

  localparam int CW = $clog2(D) + 1;
  localparam int TW = $clog2(OP_CYCLES) + 1;
  localparam logic [CW-1:0] FULL     = CW'(D);
  localparam logic [TW-1:0] T_LOAD   = TW'(OP_CYCLES - 1);
  // Timer value during the cycle ISSUE+RD_LAT, when dequeue data is valid.
  localparam logic [TW-1:0] T_SAMPLE = TW'(OP_CYCLES - RD_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          op;
  logic [TW-1:0] timer;
  logic [W-1:0]  data_l;
  logic [W-1:0]  rsp_buf;
  logic          accept;
  logic          sample;

  assign q_array_size = 32'(D);
  assign accept       = (state == IDLE) && cmd_valid && cmd_ready;
  assign sample       = (state == WAIT) && op && (timer == T_SAMPLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op        <= 1'b0;
      timer     <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      q_enq     <= 1'b0;
      q_deq     <= 1'b0;
      q_data_lt <= '0;
`ifdef QQ_DRV_ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      q_enq <= 1'b0;
      q_deq <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            op        <= cmd_op;
            if ((!cmd_op && count == FULL) || (cmd_op && count == '0)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
`ifdef QQ_DRV_ERR_CNT_EN
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
            end else begin
              state     <= ISSUE;
              q_enq     <= !cmd_op;
              q_deq     <= cmd_op;
              q_data_lt <= cmd_data;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          timer <= T_LOAD;
          count <= op ? count - 1'b1 : count + 1'b1;
        end
        WAIT: begin
          if (timer == TW'(1)) begin
            state     <= RESP;
            timer     <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            // Sampling may coincide with the last WAIT cycle when RD_LAT = OP_CYCLES-1.
            rsp_data  <= sample ? q_data_lt_o : rsp_buf;
            q_data_lt <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath response register; contents are only consumed after a full ISSUE/WAIT pass.
  always_ff @(posedge clk) begin
    if (accept) data_l <= cmd_data;
    if (state == ISSUE && !op) rsp_buf <= data_l;
    else if (sample) rsp_buf <= q_data_lt_o;
  end

endmodule

// File: tb/tb_qq_cmd_driver.sv
// Bench for qq_cmd_driver (D=4, OP_CYCLES=4, RD_LAT=2) with a stubbed queue and response scoreboard.
module tb_qq_cmd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        q_enq, q_deq;
  logic [31:0] q_data_lt, q_array_size, q_data_lt_o;
  logic [2:0]  count;
`ifdef QQ_DRV_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [32:0] sb_q[$];

  qq_cmd_driver #(.W(32), .D(4), .OP_CYCLES(4), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .q_enq(q_enq), .q_deq(q_deq), .q_data_lt(q_data_lt), .q_array_size(q_array_size),
    .q_data_lt_o(q_data_lt_o), .count(count)
`ifdef QQ_DRV_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] data;
    logic [31:0] stub;
    logic        err;
    logic [31:0] rdata;
    int          cnt;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  // Drive one command from a negedge, follow it cycle by cycle, and finish at a negedge in IDLE.
  task automatic run_cmd(input vec_t v, input int idx);
    int k;
    int pulses;
    int pulse_at;
    bit seen;
    logic [32:0] exp;
    logic        hv, he;
    logic [31:0] hd;
    pulses = 0; pulse_at = 0; seen = 0;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1'b1);
    sb_q.push_back({v.err, v.rdata});
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = '0;
    for (k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      q_data_lt_o = (k == 3 && v.op) ? v.stub : 32'h0;
      if (q_enq || q_deq) begin
        pulses++;
        pulse_at = k;
        check($sformatf("v%0d_pulse_kind", idx), {q_enq, q_deq}, v.op ? 2'b01 : 2'b10);
      end
      if (!v.err && k <= 4) check($sformatf("v%0d_q_data_lt_t%0d", idx, k), q_data_lt, v.data);
      if (k == 5 || (v.err && k == 1)) check($sformatf("v%0d_q_data_lt_idle", idx), q_data_lt, 32'h0);
      if (rsp_valid) begin
        seen = 1;
        check($sformatf("v%0d_rsp_latency", idx), k, v.err ? 1 : 5);
        check($sformatf("v%0d_cmd_ready_in_resp", idx), cmd_ready, 1'b0);
        hv = rsp_valid; hd = rsp_data; he = rsp_err;
        for (int h = 0; h < v.hold; h++) begin
          @(negedge clk);
          check($sformatf("v%0d_hold_valid", idx), rsp_valid, hv);
          check($sformatf("v%0d_hold_data", idx), rsp_data, hd);
          check($sformatf("v%0d_hold_err", idx), rsp_err, he);
          check($sformatf("v%0d_hold_ready", idx), cmd_ready, 1'b0);
          check($sformatf("v%0d_hold_pulse", idx), {q_enq, q_deq}, 2'b00);
        end
        exp = sb_q.pop_front();
        check($sformatf("v%0d_rsp_err", idx), rsp_err, exp[32]);
        check($sformatf("v%0d_rsp_data", idx), rsp_data, exp[31:0]);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle_ready", idx), cmd_ready, 1'b1);
        check($sformatf("v%0d_idle_valid", idx), rsp_valid, 1'b0);
      end
    end
    if (!seen) begin
      n_checks++; n_fails++;
      $display("FAIL v%0d_rsp_timeout: got no response, required one within 20 cycles", idx);
      void'(sb_q.pop_front());
    end
    q_data_lt_o = '0;
    check($sformatf("v%0d_pulse_count", idx), pulses, v.err ? 0 : 1);
    if (!v.err) check($sformatf("v%0d_pulse_cycle", idx), pulse_at, 1);
    check($sformatf("v%0d_count", idx), count, v.cnt);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h11,   32'h0,    1'b0, 32'h11,   1, 0};
    vecs[1]  = '{1'b1, 32'h0,    32'hABCD, 1'b0, 32'hABCD, 0, 0};
    vecs[2]  = '{1'b1, 32'h0,    32'h0,    1'b1, 32'h0,    0, 0};
    vecs[3]  = '{1'b0, 32'h5,    32'h0,    1'b0, 32'h5,    1, 0};
    vecs[4]  = '{1'b1, 32'h0,    32'hABCD, 1'b0, 32'hABCD, 0, 0};
    vecs[5]  = '{1'b0, 32'hA1,   32'h0,    1'b0, 32'hA1,   1, 0};
    vecs[6]  = '{1'b0, 32'hA2,   32'h0,    1'b0, 32'hA2,   2, 0};
    vecs[7]  = '{1'b0, 32'hA3,   32'h0,    1'b0, 32'hA3,   3, 0};
    vecs[8]  = '{1'b0, 32'hA4,   32'h0,    1'b0, 32'hA4,   4, 10};
    vecs[9]  = '{1'b0, 32'hFF,   32'h0,    1'b1, 32'h0,    4, 10};
    vecs[10] = '{1'b1, 32'h0,    32'h1234, 1'b0, 32'h1234, 3, 0};

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;
    rsp_ready = 1'b0; q_data_lt_o = '0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_count", count, 3'd0);
    check("reset_array_size", q_array_size, 32'd4);
    check("reset_pulses", {q_enq, q_deq}, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 11; i++) run_cmd(vecs[i], i);

`ifdef QQ_DRV_ERR_CNT_EN
    check("err_cnt", err_cnt, 16'd2);
`endif

    // Reset in the middle of WAIT: command dropped, no stale response afterwards.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 32'h99;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_q_data_lt", q_data_lt, 32'h0);
    check("midrst_count", count, 3'd0);
    check("midrst_outputs", {cmd_ready, rsp_valid, rsp_err, q_enq, q_deq}, 5'b0);
    check("midrst_rsp_data", rsp_data, 32'h0);
    check("midrst_array_size", q_array_size, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", cmd_ready, 1'b1);
    begin
      int stale;
      stale = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rsp_valid || q_enq || q_deq) stale++;
      end
      check("midrst_no_stale", stale, 0);
    end
    run_cmd('{1'b1, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0}, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
